// File: rtl/ps2_noise_gen.sv
// Multi-channel PS/2 device-to-host traffic generator: random frames separated by random idle gaps.
// Optional macro PS2_NOISE_ERRINJ_EN adds err_req for per-channel parity-error injection.
module ps2_noise_gen #(
    parameter int          NUM_CH     = 2,
    parameter int          DATA_BITS  = 8,
    parameter int          GAP_W      = 5,
    parameter int          MIN_GAP    = 2,
    parameter int          PARITY_ODD = 1,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bit_tick,
`ifdef PS2_NOISE_ERRINJ_EN
    input  logic [NUM_CH-1:0]             err_req,
`endif
    output logic [NUM_CH-1:0]             ps2_clk,
    output logic [NUM_CH-1:0]             ps2_data,
    output logic [NUM_CH-1:0]             frame_done,
    output logic [NUM_CH*DATA_BITS-1:0]   frame_data
);

    typedef enum logic [1:0] {ST_GAP, ST_SETUP, ST_LOW} state_e;

    localparam int                K_W       = $clog2(DATA_BITS + 3);
    localparam logic [K_W-1:0]    K_DLAST   = K_W'(DATA_BITS);
    localparam logic [K_W-1:0]    K_PAR     = K_W'(DATA_BITS + 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(DATA_BITS + 2);
    localparam logic [GAP_W:0]    MIN_GAP_V = (GAP_W + 1)'(MIN_GAP);
    localparam logic              PAR_INIT  = (PARITY_ODD != 0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] SEED_RAW = SEED ^ (16'(c) * 16'h1111);
        localparam logic [15:0] CH_SEED  = (SEED_RAW == 16'h0000) ? 16'hACE1 : SEED_RAW;

        state_e               state_q, state_d;
        logic [GAP_W:0]       gap_q, gap_d;
        logic [K_W-1:0]       k_q, k_d, k_nxt;
        logic [15:0]          lfsr_q, lfsr_d;
        logic [DATA_BITS-1:0] shad_q, shad_d;
        logic                 par_q, par_d;
        logic                 clk_q, clk_d;
        logic                 dat_q, dat_d;
        logic                 done_q, done_d;
        logic [DATA_BITS-1:0] fdata_q, fdata_d;
        logic                 inv_q, inv_d;
        logic                 flag_q, flag_d;
        logic                 err_in;

`ifdef PS2_NOISE_ERRINJ_EN
        assign err_in = err_req[c];
`else
        assign err_in = 1'b0;
`endif

        assign k_nxt = k_q + 1'b1;

        always_comb begin
            state_d = state_q;
            gap_d   = gap_q;
            k_d     = k_q;
            lfsr_d  = lfsr_q;
            shad_d  = shad_q;
            par_d   = par_q;
            clk_d   = clk_q;
            dat_d   = dat_q;
            done_d  = 1'b0;
            fdata_d = fdata_q;
            inv_d   = inv_q;
            flag_d  = flag_q;
            if (bit_tick) begin
                lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                case (state_q)
                    ST_GAP: begin
                        clk_d = 1'b1;
                        dat_d = 1'b1;
                        if (gap_q != '0) begin
                            gap_d = gap_q - 1'b1;
                        end else if (enable) begin
                            state_d = ST_SETUP;
                            k_d     = '0;
                            dat_d   = 1'b0;
                            par_d   = 1'b0;
                            inv_d   = flag_q | err_in;
                        end
                    end
                    ST_SETUP: begin
                        state_d = ST_LOW;
                        clk_d   = 1'b0;
                    end
                    ST_LOW: begin
                        clk_d = 1'b1;
                        if (k_q != K_LAST) begin
                            state_d = ST_SETUP;
                            k_d     = k_nxt;
                            if (k_nxt <= K_DLAST) begin
                                dat_d  = lfsr_q[0];
                                shad_d = {lfsr_q[0], shad_q[DATA_BITS-1:1]};
                                par_d  = par_q ^ lfsr_q[0];
                            end else if (k_nxt == K_PAR) begin
                                dat_d = par_q ^ PAR_INIT ^ inv_q;
                            end else begin
                                dat_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_GAP;
                            dat_d   = 1'b1;
                            gap_d   = MIN_GAP_V + {1'b0, lfsr_q[GAP_W-1:0]};
                            fdata_d = shad_q;
                            done_d  = 1'b1;
                            if (inv_q) begin
                                flag_d = 1'b0;
                            end
                        end
                    end
                    default: state_d = ST_GAP;
                endcase
            end
            // A request in the same clk as a clear keeps the flag armed for the following frame.
            if (err_in) begin
                flag_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_GAP;
                gap_q   <= MIN_GAP_V;
                k_q     <= '0;
                lfsr_q  <= CH_SEED;
                clk_q   <= 1'b1;
                dat_q   <= 1'b1;
                done_q  <= 1'b0;
                fdata_q <= '0;
                inv_q   <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                gap_q   <= gap_d;
                k_q     <= k_d;
                lfsr_q  <= lfsr_d;
                clk_q   <= clk_d;
                dat_q   <= dat_d;
                done_q  <= done_d;
                fdata_q <= fdata_d;
                inv_q   <= inv_d;
                flag_q  <= flag_d;
            end
        end

        // Shadow word and running parity are fully rebuilt by every frame, so they carry no reset.
        always_ff @(posedge clk) begin
            shad_q <= shad_d;
            par_q  <= par_d;
        end

        assign ps2_clk[c]                              = clk_q;
        assign ps2_data[c]                             = dat_q;
        assign frame_done[c]                           = done_q;
        assign frame_data[c*DATA_BITS +: DATA_BITS]    = fdata_q;
    end

endmodule

// File: tb/tb_ps2_noise_gen.sv
// Directed bench for ps2_noise_gen at default parameters (2 channels, 8 data bits, odd parity).
`timescale 1ns/1ps
module tb_ps2_noise_gen;
    localparam int NUM_CH    = 2;
    localparam int DATA_BITS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bit_tick;
    logic [1:0]  ps2_clk;
    logic [1:0]  ps2_data;
    logic [1:0]  frame_done;
    logic [15:0] frame_data;
`ifdef PS2_NOISE_ERRINJ_EN
    logic [1:0]  err_req;
`endif

    int checks   = 0;
    int failures = 0;

    int          tick_n;
    logic [1:0]  s_clk, s_data, s_done;
    logic [15:0] s_fdata;
    logic [1:0]  prev_clk;
    logic [10:0] sh [2];
    int          nb [2];
    logic [10:0] dec_bits [2];
    int          dec_n [2];
    int          done_tick [2];
    bit          gap_new [2];
    int          gap_val [2];
    logic [7:0]  first_word [2];

    always #5 clk = ~clk;

    ps2_noise_gen #(
        .NUM_CH(NUM_CH), .DATA_BITS(DATA_BITS), .GAP_W(5), .MIN_GAP(2),
        .PARITY_ODD(1), .SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_tick   (bit_tick),
`ifdef PS2_NOISE_ERRINJ_EN
        .err_req    (err_req),
`endif
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .frame_done (frame_done),
        .frame_data (frame_data)
    );

    function automatic logic [15:0] lfsr_after(input int c, input int n);
        logic [15:0] x;
        x = 16'hACE1 ^ (16'(c) * 16'h1111);
        if (x == 16'h0000) x = 16'hACE1;
        for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        return x;
    endfunction

    // Data bit i is lfsr[0] after 4+2i ticks: start SETUP on tick 3, data SETUPs on ticks 5,7,...
    function automatic logic [7:0] exp_word(input int c);
        logic [7:0]  w;
        logic [15:0] x;
        for (int i = 0; i < 8; i++) begin
            x    = lfsr_after(c, 4 + 2 * i);
            w[i] = x[0];
        end
        return w;
    endfunction

    function automatic int exp_gap(input int c);
        logic [15:0] x;
        x = lfsr_after(c, 24);
        return 2 + int'(x[4:0]);
    endfunction

    task automatic dec_reset();
        tick_n   = 0;
        prev_clk = 2'b11;
        for (int c = 0; c < 2; c++) begin
            nb[c] = 0; sh[c] = '0; done_tick[c] = -1; gap_new[c] = 1'b0; dec_n[c] = 0;
        end
    endtask

    // One bit_tick pulse, then sample outputs on the following negedge and decode falling ps2_clk.
    task automatic tick(input int spacing);
        @(negedge clk);
        bit_tick = 1'b1;
        @(negedge clk);
        bit_tick = 1'b0;
        tick_n++;
        s_clk = ps2_clk; s_data = ps2_data; s_done = frame_done; s_fdata = frame_data;
        for (int c = 0; c < 2; c++) begin
            gap_new[c] = 1'b0;
            if (prev_clk[c] && !s_clk[c]) begin
                if (nb[c] == 0 && done_tick[c] >= 0) begin
                    gap_new[c] = 1'b1;
                    gap_val[c] = tick_n - done_tick[c] - 2;
                end
                if (nb[c] < 11) sh[c][nb[c]] = s_data[c];
                nb[c]++;
            end
            if (s_done[c]) begin
                dec_bits[c] = sh[c]; dec_n[c] = nb[c];
                nb[c] = 0; sh[c] = '0; done_tick[c] = tick_n;
            end
            prev_clk[c] = s_clk[c];
        end
        repeat (spacing - 2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) tick(4);
        @(negedge clk);
        reset = 1'b0;
        dec_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_tick = (i % 2 == 0);
            @(negedge clk);
            checks++; if (ps2_clk !== 2'b11) begin failures++; $display("FAIL reset_clk got=%b want=11", ps2_clk); end
            checks++; if (ps2_data !== 2'b11) begin failures++; $display("FAIL reset_data got=%b want=11", ps2_data); end
            checks++; if (frame_done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b want=00", frame_done); end
            checks++; if (frame_data !== 16'h0) begin failures++; $display("FAIL reset_fdata got=%h want=0000", frame_data); end
        end
        bit_tick = 1'b0;
    endtask

    task automatic test_first_frame();
        logic [1:0] any_done;
        bit         seen0, seen1;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        dec_reset();
        tick(4); tick(4);
        checks++; if ({s_clk, s_data} !== 4'b1111) begin failures++; $display("FAIL gap_lines got=%b want=1111", {s_clk, s_data}); end
        tick(4);
        checks++; if ({s_clk, s_data} !== 4'b1100) begin failures++; $display("FAIL start_setup got=%b want=1100", {s_clk, s_data}); end
        tick(4);
        checks++; if ({s_clk, s_data} !== 4'b0000) begin failures++; $display("FAIL start_low got=%b want=0000", {s_clk, s_data}); end
        any_done = 2'b00;
        for (int t = 5; t <= 24; t++) begin
            tick(4);
            any_done |= s_done;
        end
        checks++; if (any_done !== 2'b00) begin failures++; $display("FAIL early_done got=%b want=00", any_done); end
        tick(4);
        checks++; if (s_done !== 2'b11) begin failures++; $display("FAIL done_tick25 got=%b want=11", s_done); end
        checks++; if (s_fdata !== {exp_word(1), exp_word(0)}) begin failures++; $display("FAIL first_word got=%h want=%h", s_fdata, {exp_word(1), exp_word(0)}); end
        checks++; if (dec_n[0] !== 11) begin failures++; $display("FAIL first_bits got=%0d want=11", dec_n[0]); end
        checks++; if (frame_done !== 2'b00) begin failures++; $display("FAIL done_width got=%b want=00", frame_done); end
        first_word[0] = s_fdata[7:0];
        first_word[1] = s_fdata[15:8];
        seen0 = 1'b0; seen1 = 1'b0;
        for (int t = 0; t < 60 && !(seen0 && seen1); t++) begin
            tick(4);
            if (gap_new[0]) begin
                seen0 = 1'b1;
                checks++; if (gap_val[0] !== exp_gap(0)) begin failures++; $display("FAIL gap_ch0 got=%0d want=%0d", gap_val[0], exp_gap(0)); end
            end
            if (gap_new[1]) begin
                seen1 = 1'b1;
                checks++; if (gap_val[1] !== exp_gap(1)) begin failures++; $display("FAIL gap_ch1 got=%0d want=%0d", gap_val[1], exp_gap(1)); end
            end
        end
        checks++; if ({seen1, seen0} !== 2'b11) begin failures++; $display("FAIL second_start_timeout got=%b want=11", {seen1, seen0}); end
    endtask

    task automatic test_free_run();
        int frames [2];
        frames[0] = 0; frames[1] = 0;
        for (int t = 0; t < 12000 && (frames[0] < 200 || frames[1] < 200); t++) begin
            tick(2);
            for (int c = 0; c < 2; c++) begin
                if (gap_new[c]) begin
                    checks++; if (gap_val[c] < 2 || gap_val[c] > 33) begin failures++; $display("FAIL gap_range ch%0d got=%0d want=2..33", c, gap_val[c]); end
                end
                if (s_done[c] && frames[c] < 200) begin
                    frames[c]++;
                    checks++; if (dec_n[c] !== 11) begin failures++; $display("FAIL nbits ch%0d got=%0d want=11", c, dec_n[c]); end
                    checks++; if (dec_bits[c][0] !== 1'b0) begin failures++; $display("FAIL start_bit ch%0d got=%b want=0", c, dec_bits[c][0]); end
                    checks++; if (dec_bits[c][10] !== 1'b1) begin failures++; $display("FAIL stop_bit ch%0d got=%b want=1", c, dec_bits[c][10]); end
                    checks++; if (^dec_bits[c][9:1] !== 1'b1) begin failures++; $display("FAIL parity ch%0d got=%b want=1", c, ^dec_bits[c][9:1]); end
                    checks++; if (dec_bits[c][8:1] !== s_fdata[c*8 +: 8]) begin failures++; $display("FAIL word ch%0d got=%h want=%h", c, s_fdata[c*8 +: 8], dec_bits[c][8:1]); end
                end
            end
        end
        checks++; if (frames[0] != 200 || frames[1] != 200) begin failures++; $display("FAIL free_run_count got=%0d/%0d want=200/200", frames[0], frames[1]); end
    endtask

    task automatic test_enable_gate();
        int  t_done;
        int  t_start;
        bit  idle_ok;
        apply_reset();
        enable = 1'b1;
        repeat (11) tick(4);
        checks++; if (nb[0] !== 4 || s_clk[0] !== 1'b1) begin failures++; $display("FAIL at_data3 got=nb%0d clk%b want=nb4 clk1", nb[0], s_clk[0]); end
        enable = 1'b0;
        t_done = -1;
        for (int t = 0; t < 30 && t_done < 0; t++) begin
            tick(4);
            if (s_done[0]) t_done = tick_n;
        end
        checks++; if (t_done !== 25) begin failures++; $display("FAIL gated_done_tick got=%0d want=25", t_done); end
        checks++; if (dec_n[0] !== 11) begin failures++; $display("FAIL gated_bits got=%0d want=11", dec_n[0]); end
        idle_ok = 1'b1;
        for (int t = 0; t < 100; t++) begin
            tick(4);
            if (s_clk !== 2'b11 || s_data !== 2'b11 || s_done !== 2'b00) idle_ok = 1'b0;
        end
        checks++; if (idle_ok !== 1'b1) begin failures++; $display("FAIL idle_hold got=%b want=1", idle_ok); end
        enable  = 1'b1;
        t_start = -1;
        for (int t = 1; t <= 40 && t_start < 0; t++) begin
            tick(4);
            if (s_clk[0] && !s_data[0]) t_start = t;
        end
        checks++; if (t_start < 1 || t_start > 34) begin failures++; $display("FAIL restart_ticks got=%0d want=1..34", t_start); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w1;
        logic [1:0] any_done;
        int         t_done;
        apply_reset();
        enable = 1'b1;
        repeat (21) tick(4);
        w1 = exp_word(1);
        checks++; if (s_clk[1] !== 1'b1 || s_data[1] !== ~^w1) begin failures++; $display("FAIL parity_setup got=clk%b dat%b want=clk1 dat%b", s_clk[1], s_data[1], ~^w1); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ps2_clk[1] !== 1'b1 || ps2_data[1] !== 1'b1) begin failures++; $display("FAIL midreset_lines got=%b%b want=11", ps2_clk[1], ps2_data[1]); end
        checks++; if (frame_done !== 2'b00) begin failures++; $display("FAIL midreset_done got=%b want=00", frame_done); end
        any_done = 2'b00;
        repeat (3) begin
            tick(4);
            any_done |= s_done;
        end
        checks++; if (any_done !== 2'b00) begin failures++; $display("FAIL reset_hold_done got=%b want=00", any_done); end
        @(negedge clk);
        reset = 1'b0;
        dec_reset();
        t_done = -1;
        for (int t = 0; t < 40 && t_done < 0; t++) begin
            tick(4);
            if (s_done[0]) t_done = tick_n;
        end
        checks++; if (t_done !== 25) begin failures++; $display("FAIL rerun_done_tick got=%0d want=25", t_done); end
        checks++; if (s_fdata !== {exp_word(1), exp_word(0)}) begin failures++; $display("FAIL rerun_word got=%h want=%h", s_fdata, {exp_word(1), exp_word(0)}); end
        checks++; if (s_fdata !== {first_word[1], first_word[0]}) begin failures++; $display("FAIL rerun_repeat got=%h want=%h", s_fdata, {first_word[1], first_word[0]}); end
    endtask

`ifdef PS2_NOISE_ERRINJ_EN
    task automatic test_err_inject();
        int n0;
        bit found;
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            tick(4);
            if (s_done[0]) found = 1'b1;
        end
        @(negedge clk);
        err_req = 2'b01;
        @(negedge clk);
        err_req = 2'b00;
        n0 = 0;
        for (int t = 0; t < 200 && n0 < 2; t++) begin
            tick(4);
            if (s_done[1]) begin
                checks++; if (^dec_bits[1][9:1] !== 1'b1) begin failures++; $display("FAIL errinj_ch1 got=%b want=1", ^dec_bits[1][9:1]); end
            end
            if (s_done[0]) begin
                n0++;
                if (n0 == 1) begin
                    checks++; if (^dec_bits[0][9:1] !== 1'b0) begin failures++; $display("FAIL errinj_bad got=%b want=0", ^dec_bits[0][9:1]); end
                end else begin
                    checks++; if (^dec_bits[0][9:1] !== 1'b1) begin failures++; $display("FAIL errinj_good got=%b want=1", ^dec_bits[0][9:1]); end
                end
            end
        end
        checks++; if (n0 != 2 || !found) begin failures++; $display("FAIL errinj_timeout got=%0d want=2", n0); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        bit_tick = 1'b0;
`ifdef PS2_NOISE_ERRINJ_EN
        err_req  = 2'b00;
`endif
        dec_reset();
        test_reset();
        test_first_frame();
        test_free_run();
        test_enable_gate();
        test_reset_mid_frame();
`ifdef PS2_NOISE_ERRINJ_EN
        test_err_inject();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
